// File: rtl/mem_responder.sv
// mem_responder
// Memory-side responder for the core's instruction and data ports. Each port
// accepts one request per cycle (nonzero mask = request), is serviced against
// an internal byte-maskable word array, and returns a one-cycle resp strobe
// with read data exactly LATENCY cycles after acceptance.
//
// Ports:
//   clk, rst                 clock; synchronous active-high reset
//   imem_addr/rmask          instruction request (byte address, read mask)
//   imem_rdata/resp          instruction response (data is 0 when resp low)
//   dmem_addr/rmask/wmask/wdata  data request (read or byte-masked write)
//   dmem_rdata/resp          data response (writes and illegal requests return 0)
//   ld_en/ld_idx/ld_data     backdoor preload, active even during reset
//   err                      sticky flag for any illegal request, cleared by rst
module mem_responder #(
  parameter int          LATENCY     = 2,
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h1eceb000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [31:0]                    imem_addr,
  input  logic [3:0]                     imem_rmask,
  output logic [31:0]                    imem_rdata,
  output logic                           imem_resp,
  input  logic [31:0]                    dmem_addr,
  input  logic [3:0]                     dmem_rmask,
  input  logic [3:0]                     dmem_wmask,
  input  logic [31:0]                    dmem_wdata,
  output logic [31:0]                    dmem_rdata,
  output logic                           dmem_resp,
  input  logic                           ld_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] ld_idx,
  input  logic [31:0]                    ld_data,
  output logic                           err
);

  localparam int          IW   = $clog2(DEPTH_WORDS);
  // Byte span of the array, one bit wider so large depths cannot overflow.
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

  logic [31:0] mem_q [DEPTH_WORDS];

  // Request decode. Offsets are unsigned, so addresses below BASE_ADDR wrap
  // to huge values and fall out of range automatically.
  logic [31:0]   i_off, d_off;
  logic [IW-1:0] i_idx, d_idx;
  logic          i_req, i_legal;
  logic          d_rd, d_wr, d_req, d_legal;

  assign i_off   = imem_addr - BASE_ADDR;
  assign d_off   = dmem_addr - BASE_ADDR;
  assign i_idx   = i_off[IW+1:2];
  assign d_idx   = d_off[IW+1:2];

  assign i_req   = (|imem_rmask) && !rst;
  assign i_legal = (i_off[1:0] == 2'b00) && ({1'b0, i_off} < SPAN);

  assign d_rd    = |dmem_rmask;
  assign d_wr    = |dmem_wmask;
  assign d_req   = (d_rd || d_wr) && !rst;
  assign d_legal = (d_off[1:0] == 2'b00) && ({1'b0, d_off} < SPAN) && !(d_rd && d_wr);

  // Stage-0 read data is sampled from the array before this edge's writes
  // land, so an imem read colliding with a dmem write sees the old word.
  logic [31:0] i_rdata_d, d_rdata_d;

  assign i_rdata_d = (i_req && i_legal) ? mem_q[i_idx] : '0;
  assign d_rdata_d = (d_req && d_legal && !d_wr) ? mem_q[d_idx] : '0;

  // Array: byte-masked dmem write, then preload. Preload is written last so
  // it wins when both target the same word.
  always_ff @(posedge clk) begin
    if (d_req && d_legal && d_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (dmem_wmask[b]) mem_q[d_idx][8*b +: 8] <= dmem_wdata[8*b +: 8];
      end
    end
    if (ld_en) mem_q[ld_idx] <= ld_data;
  end

  // Response pipelines: stage 0 is loaded at the acceptance edge, stage
  // LATENCY-1 drives the outputs. Only the valid bits are reset; stale data
  // is masked at the output instead.
  logic [LATENCY-1:0] i_vld_q, d_vld_q;
  logic [31:0]        i_dat_q [LATENCY];
  logic [31:0]        d_dat_q [LATENCY];

  always_ff @(posedge clk) begin
    if (rst) begin
      i_vld_q <= '0;
      d_vld_q <= '0;
    end else begin
      i_vld_q[0] <= i_req;
      d_vld_q[0] <= d_req;
      for (int s = 1; s < LATENCY; s++) begin
        i_vld_q[s] <= i_vld_q[s-1];
        d_vld_q[s] <= d_vld_q[s-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    i_dat_q[0] <= i_rdata_d;
    d_dat_q[0] <= d_rdata_d;
    for (int s = 1; s < LATENCY; s++) begin
      i_dat_q[s] <= i_dat_q[s-1];
      d_dat_q[s] <= d_dat_q[s-1];
    end
  end

  assign imem_resp  = i_vld_q[LATENCY-1];
  assign dmem_resp  = d_vld_q[LATENCY-1];
  assign imem_rdata = imem_resp ? i_dat_q[LATENCY-1] : '0;
  assign dmem_rdata = dmem_resp ? d_dat_q[LATENCY-1] : '0;

  // Sticky error: any accepted illegal request on either port.
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if ((i_req && !i_legal) || (d_req && !d_legal)) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  localparam logic [31:0] BASE  = 32'h1eceb000;
  localparam int          DEPTH = 1024;
  localparam int          HMAX  = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] imem_addr, dmem_addr, dmem_wdata, ld_data;
  logic [3:0]  imem_rmask, dmem_rmask, dmem_wmask;
  logic        ld_en;
  logic [9:0]  ld_idx;

  logic [31:0] i_rdata2, d_rdata2, i_rdata4, d_rdata4;
  logic        i_resp2, d_resp2, i_resp4, d_resp4, err2, err4;

  mem_responder #(.LATENCY(2), .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) u_l2 (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_rmask(imem_rmask),
    .imem_rdata(i_rdata2), .imem_resp(i_resp2),
    .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask),
    .dmem_wdata(dmem_wdata), .dmem_rdata(d_rdata2), .dmem_resp(d_resp2),
    .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data), .err(err2)
  );

  mem_responder #(.LATENCY(4), .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) u_l4 (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_rmask(imem_rmask),
    .imem_rdata(i_rdata4), .imem_resp(i_resp4),
    .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask),
    .dmem_wdata(dmem_wdata), .dmem_rdata(d_rdata4), .dmem_resp(d_resp4),
    .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data), .err(err4)
  );

  // Reference model: a word array plus a per-edge history of what was
  // accepted. The expected output of a latency-L instance after edge E is
  // the request accepted at edge E-L+1, unless a reset edge intervened.
  logic [31:0] mm [DEPTH];
  bit          hr   [HMAX];
  bit          hv_i [HMAX];
  bit          hv_d [HMAX];
  logic [31:0] hd_i [HMAX];
  logic [31:0] hd_d [HMAX];
  int          ne = 0;
  bit          err_m = 1'b0;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit in_map(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return ((off % 4) == 0) && (off < 32'(4 * DEPTH));
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) / 4);
  endfunction

  task automatic model_edge();
    bit ireq, il, drd, dwr, dreq, dl;
    int e;
    e       = ne;
    hr[e]   = rst;
    ireq    = (imem_rmask != 0) && !rst;
    il      = in_map(imem_addr);
    hv_i[e] = ireq;
    hd_i[e] = 32'h0;
    if (ireq && il) hd_i[e] = mm[widx(imem_addr)];
    drd     = dmem_rmask != 0;
    dwr     = dmem_wmask != 0;
    dreq    = (drd || dwr) && !rst;
    dl      = in_map(dmem_addr) && !(drd && dwr);
    hv_d[e] = dreq;
    hd_d[e] = 32'h0;
    if (dreq && dl && !dwr) hd_d[e] = mm[widx(dmem_addr)];
    if (rst) err_m = 1'b0;
    else if ((ireq && !il) || (dreq && !dl)) err_m = 1'b1;
    if (dreq && dl && dwr) begin
      for (int b = 0; b < 4; b++)
        if (dmem_wmask[b]) mm[widx(dmem_addr)][8*b +: 8] = dmem_wdata[8*b +: 8];
    end
    if (ld_en) mm[ld_idx] = ld_data;
    ne++;
  endtask

  function automatic logic [32:0] expect_out(input bit dport, input int lat);
    int n;
    bit v;
    n = ne - lat;
    if (n < 0) return 33'h0;
    v = dport ? hv_d[n] : hv_i[n];
    for (int k = n; k < ne; k++) if (hr[k]) v = 1'b0;
    if (!v) return 33'h0;
    return {1'b1, (dport ? hd_d[n] : hd_i[n])};
  endfunction

  task automatic cyc();
    logic [32:0] x;
    @(posedge clk);
    model_edge();
    #1;
    x = expect_out(1'b0, 2);
    chk("l2_imem_resp",  {31'b0, i_resp2}, {31'b0, x[32]});
    chk("l2_imem_rdata", i_rdata2, x[31:0]);
    x = expect_out(1'b1, 2);
    chk("l2_dmem_resp",  {31'b0, d_resp2}, {31'b0, x[32]});
    chk("l2_dmem_rdata", d_rdata2, x[31:0]);
    x = expect_out(1'b0, 4);
    chk("l4_imem_resp",  {31'b0, i_resp4}, {31'b0, x[32]});
    chk("l4_imem_rdata", i_rdata4, x[31:0]);
    x = expect_out(1'b1, 4);
    chk("l4_dmem_resp",  {31'b0, d_resp4}, {31'b0, x[32]});
    chk("l4_dmem_rdata", d_rdata4, x[31:0]);
    chk("l2_err", {31'b0, err2}, {31'b0, err_m});
    chk("l4_err", {31'b0, err4}, {31'b0, err_m});
  endtask

  task automatic idle();
    imem_rmask = 4'h0; dmem_rmask = 4'h0; dmem_wmask = 4'h0; ld_en = 1'b0;
  endtask

  task automatic cycn(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  logic [31:0] old8;
  int          w;
  int          op;

  initial begin
    rst = 1'b1; imem_addr = BASE; dmem_addr = BASE; dmem_wdata = 0;
    ld_data = 0; ld_idx = 0;
    idle();

    // Fill the whole array through the backdoor, partly while in reset.
    for (int i = 0; i < DEPTH; i++) begin
      rst = (i < 8); ld_en = 1'b1; ld_idx = 10'(i); ld_data = $urandom;
      cyc();
    end
    ld_idx = 10'd0; ld_data = 32'h00000013; cyc();
    ld_idx = 10'd3; ld_data = 32'h11223344; cyc();
    idle(); cyc();

    // Preload and fetch.
    imem_addr = BASE; imem_rmask = 4'hf; cyc();
    idle(); cyc();
    chk("fetch_resp",  {31'b0, i_resp2}, 32'h1);
    chk("fetch_rdata", i_rdata2, 32'h00000013);
    cycn(3);

    // Streaming fetch of eight words.
    for (int k = 0; k < 8; k++) begin
      imem_addr = BASE + 32'(4 * k); imem_rmask = 4'hf; cyc();
    end
    idle(); cycn(5);

    // Byte-masked write then read back.
    dmem_addr = BASE + 32'hc; dmem_wmask = 4'b0110; dmem_wdata = 32'hAABBCCDD; cyc();
    dmem_wmask = 4'h0; dmem_rmask = 4'hf; cyc();
    chk("bytewrite_resp",  {31'b0, d_resp2}, 32'h1);
    chk("bytewrite_rdata", d_rdata2, 32'h0);
    idle(); cyc();
    chk("byteread_rdata", d_rdata2, 32'h11BBCC44);
    cycn(3);

    // Same-cycle imem read / dmem write to word 8.
    old8 = mm[8];
    imem_addr = BASE + 32'h20; imem_rmask = 4'hf;
    dmem_addr = BASE + 32'h20; dmem_wmask = 4'hf; dmem_wdata = 32'hDEADBEEF; cyc();
    dmem_wmask = 4'h0; cyc();
    chk("conflict_old", i_rdata2, old8);
    idle(); cyc();
    chk("conflict_new", i_rdata2, 32'hDEADBEEF);
    cycn(3);

    // Illegal requests: misaligned, below base, read+write together.
    dmem_rmask = 4'hf; dmem_addr = BASE + 32'h2; cyc();
    dmem_addr = BASE - 32'h1; cyc();
    dmem_addr = BASE + 32'h10; dmem_wmask = 4'hf; dmem_wdata = 32'hFFFFFFFF; cyc();
    idle(); cycn(4);
    chk("err_sticky", {31'b0, err2}, 32'h1);
    dmem_addr = BASE + 32'h10; dmem_rmask = 4'hf; cyc();
    idle(); cycn(4);

    // Reset with reads in flight.
    for (int k = 0; k < 3; k++) begin
      imem_addr = BASE + 32'(4 * k); imem_rmask = 4'hf;
      dmem_addr = BASE + 32'(4 * (k + 3)); dmem_rmask = 4'hf; cyc();
    end
    idle(); rst = 1'b1; cyc();
    rst = 1'b0;
    chk("rst_err_clear", {31'b0, err4}, 32'h0);
    cycn(6);
    imem_addr = BASE + 32'hc; imem_rmask = 4'hf;
    dmem_addr = BASE + 32'h20; dmem_rmask = 4'hf; cyc();
    idle(); cycn(5);

    // Randomized traffic on both ports.
    for (int t = 0; t < 400; t++) begin
      rst = ($urandom_range(0, 59) == 0);
      w = $urandom_range(0, DEPTH - 1);
      imem_addr = BASE + 32'(4 * w);
      if ($urandom_range(0, 39) == 0) imem_addr = imem_addr + 32'($urandom_range(1, 3));
      imem_rmask = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'(($urandom_range(1, 15)));
      w = $urandom_range(0, 15);
      dmem_addr = BASE + 32'(4 * w);
      if ($urandom_range(0, 39) == 0) dmem_addr = BASE + 32'(4 * DEPTH) + 32'(4 * w);
      dmem_wdata = $urandom;
      op = $urandom_range(0, 19);
      dmem_rmask = 4'h0; dmem_wmask = 4'h0;
      if (op < 6)        dmem_rmask = 4'(($urandom_range(1, 15)));
      else if (op < 12)  dmem_wmask = 4'(($urandom_range(1, 15)));
      else if (op == 12) begin dmem_rmask = 4'hf; dmem_wmask = 4'h1; end
      ld_en   = ($urandom_range(0, 7) == 0);
      ld_idx  = 10'($urandom_range(0, 15));
      ld_data = $urandom;
      cyc();
    end
    rst = 1'b0; idle(); cycn(6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the pipelined core's instruction and data memory ports. It accepts the core's per-cycle requests (nonzero mask = request), services them against an internal byte-maskable word array, and returns `*_resp` with read data a fixed `LATENCY` cycles later. The block is fully pipelined and accepts a new request on each port every cycle. It sits opposite the core in the core-level testbench and in the FPGA bring-up top.

## Interface
- `LATENCY`, 2: request-to-response delay in cycles; legal range 1–8.
- `DEPTH_WORDS`, 1024: number of 32-bit words in the array; power of two.
- `BASE_ADDR`, 32'h1eceb000: byte address of word 0; word-aligned.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `imem_addr`  in  32  instruction byte address.
- `imem_rmask`  in  4  instruction read mask; nonzero = request this cycle.
- `imem_rdata`  out  32  instruction read data.
- `imem_resp`  out  1  one-cycle instruction response strobe.
- `dmem_addr`  in  32  data byte address.
- `dmem_rmask`  in  4  data read mask.
- `dmem_wmask`  in  4  data write byte enables.
- `dmem_wdata`  in  32  data write data; byte i sits on bits [8i+7:8i].
- `dmem_rdata`  out  32  data read data.
- `dmem_resp`  out  1  one-cycle data response strobe.
- `ld_en`  in  1  backdoor preload enable.
- `ld_idx`  in  log2(DEPTH_WORDS)  preload word index.
- `ld_data`  in  32  preload word.
- `err`  out  1  sticky error flag.

## Operation
- **Acceptance.** A port request is accepted at the rising edge that ends any cycle where its mask is nonzero and `rst` is low. There is no backpressure. The core holds an unchanged address across a stall, and each held cycle counts as a new request.
- **Decode.**
  - `idx = (addr - BASE_ADDR) >> 2`.
  - A request is legal only if `addr[1:0]==0` and `addr - BASE_ADDR < 4*DEPTH_WORDS`, computed unsigned in 32 bits. Addresses below `BASE_ADDR` wrap to large values and are therefore out of range.
- **Read.** Captures the full 32-bit word at `idx` at the acceptance edge. The whole word is returned regardless of `rmask`; the core extracts bytes.
- **Write.**
  - Bytes whose `wmask` bit is set are written at the acceptance edge; other bytes are unchanged.
  - A write still produces `dmem_resp` after `LATENCY` cycles, with `dmem_rdata` = 0.
- **Illegal requests.** These are: out of range, misaligned, or `dmem_rmask` and `dmem_wmask` both nonzero. For any of these:
  - no array write occurs;
  - a response is still returned, with rdata 0;
  - `err` sets and stays set until reset.
- **Same-cycle conflicts.**
  - imem read and dmem write to the same word in the same cycle: imem returns the old data.
  - dmem write and `ld_en` to the same word: `ld_en` wins.
- **Response pipeline.** Each port has a `LATENCY`-deep shift register of {valid, rdata}. The stage at the output drives `*_resp` and `*_rdata`. When `*_resp` is low, `*_rdata` is 0.
- **Backdoor preload.** `ld_en` writes `ld_data` to word `ld_idx` at the edge. It works during reset and produces no response.
- **Array reset.** The array has no reset; contents survive `rst`.

## Timing
- **Reset values.** `imem_resp`=0, `dmem_resp`=0, `imem_rdata`=0, `dmem_rdata`=0, `err`=0. All pipeline valid bits are cleared.
- **Latency.** A request accepted at edge N has its resp high for exactly one cycle, the cycle after edge N+LATENCY-1. With `LATENCY`=1, resp is high in the cycle immediately after the request cycle.
- **Throughput.** Back-to-back requests on K consecutive cycles produce K consecutive resp cycles, in order, one per request.
- **Port independence.** The two ports are fully independent and may respond in the same cycle.
- **Reset mid-operation.** In-flight responses are dropped and never appear. Writes already accepted remain in the array. A request presented in a cycle with `rst` high is ignored.
- **Read-after-write.** A dmem write at edge N followed by a read accepted at edge N+1 or later, from either port, returns the new data.

## Test plan
- **Preload and fetch.** Preload word 0 = 32'h00000013 via `ld_en`; `imem_addr`=32'h1eceb000, `imem_rmask`=4'hf for one cycle, `LATENCY`=2 → `imem_resp` high exactly 2 cycles later with `imem_rdata`=32'h00000013, and 0 otherwise.
- **Streaming.** 8 consecutive imem requests at addresses +0,+4,…,+28 → 8 consecutive resp cycles returning the preloaded words in order.
- **Byte-masked write.** Word 3 = 32'h11223344; dmem write at 32'h1eceb00c, `wmask`=4'b0110, `wdata`=32'hAABBCCDD; then read → 32'h11BBCC44. The write resp carries rdata 0.
- **Same-cycle conflict.** imem read and dmem write (`wmask`=4'hf, 32'hDEADBEEF) to the same word in the same cycle → imem returns old data; an imem read one cycle later returns 32'hDEADBEEF.
- **Illegal requests.** dmem read at 32'h1eceb002, at 32'h1eceafff, and with rmask+wmask both nonzero → each gets a resp with rdata 0; `err` rises after the first and stays high; the array is unchanged.
- **Reset mid-flight.** `LATENCY`=4; issue 3 reads, then assert `rst` one cycle → no resp ever appears for those reads; `err` clears; preloaded and written data are still readable after reset.
